// File: rtl/sine_deserializer.sv
// Rebuilds MSB-first serial sine samples into parallel words, with a sample counter and framing-error pulse.
// Optional unsigned peak tracking is enabled by defining SINE_DESER_PEAK_EN.
module sine_deserializer #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  SI,
    input  logic                  SI_en,
    input  logic                  soc,
`ifdef SINE_DESER_PEAK_EN
    input  logic                  peak_clr,
    output logic [DATA_WIDTH-1:0] peak_max,
    output logic [DATA_WIDTH-1:0] peak_min,
`endif
    output logic [DATA_WIDTH-1:0] pdata_out,
    output logic                  data_valid,
    output logic                  busy,
    output logic                  frame_err,
    output logic [CNT_WIDTH-1:0]  sample_cnt
);

    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
    logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   pdata_q, pdata_d;
    logic                    dv_q, dv_d;
    logic                    err_q, err_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    start;
    logic [DATA_WIDTH-1:0]   shifted;

    assign shifted = {shreg_q[DATA_WIDTH-2:0], SI};

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        pdata_d   = pdata_q;
        dv_d      = 1'b0;
        err_d     = 1'b0;
        cnt_d     = cnt_q;
        start     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (soc) begin
                    start = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (soc) begin
                    // Restart before any bit arrived is harmless; otherwise the partial frame is lost.
                    start = 1'b1;
                    err_d = (bit_cnt_q != '0);
                end else if (SI_en) begin
                    shreg_d = shifted;
                    if (bit_cnt_q == LAST_BIT) begin
                        // Output registers load here so data_valid and pdata_out appear together in DONE.
                        pdata_d   = shifted;
                        dv_d      = 1'b1;
                        cnt_d     = cnt_q + CNT_WIDTH'(1);
                        bit_cnt_d = '0;
                        state_d   = DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (start) begin
            state_d = SHIFT;
            shreg_d = '0;
            if (SI_en) begin
                shreg_d[0] = SI;
                bit_cnt_d  = BW'(1);
            end else begin
                bit_cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            pdata_q   <= '0;
            dv_q      <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            pdata_q   <= pdata_d;
            dv_q      <= dv_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef SINE_DESER_PEAK_EN
    logic [DATA_WIDTH-1:0] peak_max_q, peak_min_q;

    always_ff @(posedge clk) begin
        if (!rst_n || peak_clr) begin
            peak_max_q <= '0;
            peak_min_q <= '1;
        end else if (dv_d) begin
            if (shifted > peak_max_q) peak_max_q <= shifted;
            if (shifted < peak_min_q) peak_min_q <= shifted;
        end
    end

    assign peak_max = peak_max_q;
    assign peak_min = peak_min_q;
`endif

    assign pdata_out  = pdata_q;
    assign data_valid = dv_q;
    assign busy       = (state_q == SHIFT);
    assign frame_err  = err_q;
    assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_sine_deserializer.sv
// Directed bench for sine_deserializer: stimulus pushes expected samples, a negedge monitor pops and compares.
module tb_sine_deserializer;
    localparam int DW = 8;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          SI = 1'b0;
    logic          SI_en = 1'b0;
    logic          soc = 1'b0;
    logic [DW-1:0] pdata_out;
    logic          data_valid;
    logic          busy;
    logic          frame_err;
    logic [CW-1:0] sample_cnt;
`ifdef SINE_DESER_PEAK_EN
    logic          peak_clr = 1'b0;
    logic [DW-1:0] peak_max;
    logic [DW-1:0] peak_min;
`endif

    sine_deserializer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .SI         (SI),
        .SI_en      (SI_en),
        .soc        (soc),
`ifdef SINE_DESER_PEAK_EN
        .peak_clr   (peak_clr),
        .peak_max   (peak_max),
        .peak_min   (peak_min),
`endif
        .pdata_out  (pdata_out),
        .data_valid (data_valid),
        .busy       (busy),
        .frame_err  (frame_err),
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   dv_seen  = 0;
    int   err_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (frame_err === 1'b1) err_seen++;
        if (data_valid === 1'b1) begin
            dv_seen++;
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected_dv: got pdata %0h with empty scoreboard", pdata_out);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_pdata", 32'(pdata_out), 32'(e.d));
                check("sb_cnt", 32'(sample_cnt), 32'(e.c));
            end
        end
    end

    task automatic drive(input logic s, input logic e, input logic b);
        @(negedge clk);
        soc   = s;
        SI_en = e;
        SI    = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(i[0], 1'b1, ~i[0]);
            check("rst_pdata", 32'(pdata_out), 0);
            check("rst_dv", 32'(data_valid), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_err", 32'(frame_err), 0);
            check("rst_cnt", 32'(sample_cnt), 0);
        end
        drive(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    // Sends the first nbits of d MSB first; only complete frames are expected on the output.
    task automatic frame(input logic [DW-1:0] d, input bit gapped, input bit prev_done,
                         input logic [CW-1:0] c, input int nbits);
        bit busy_bad;
        busy_bad = 1'b0;
        if (nbits == DW) sb_q.push_back({d, c});
        for (int i = 0; i < nbits; i++) begin
            drive(i == 0, 1'b1, d[DW-1-i]);
            if (i == 0 && prev_done) check("b2b_dv_in_done", 32'(data_valid), 1);
            if (i > 0 && busy !== 1'b1) busy_bad = 1'b1;
            if (gapped && (i == 2 || i == 5)) begin
                for (int g = 0; g < 2; g++) begin
                    drive(1'b0, 1'b0, 1'b0);
                    if (busy !== 1'b1) busy_bad = 1'b1;
                end
            end
        end
        check("busy_in_frame", 32'(busy_bad), 0);
    endtask

    task automatic finish_frame(input string name);
        drive(1'b0, 1'b0, 1'b0);
        check({name, "_dv_on_time"}, 32'(data_valid), 1);
        check({name, "_busy_done"}, 32'(busy), 0);
        drive(1'b0, 1'b0, 1'b0);
        check({name, "_dv_one_cycle"}, 32'(data_valid), 0);
    endtask

    initial begin
        int d0;
        int e0;

        do_reset();

        // Single frame 1,0,1,1,0,1,0,0
        frame(8'hB4, 1'b0, 1'b0, 2'd1, 8);
        finish_frame("single");
        check("single_pdata_hold", 32'(pdata_out), 32'h0B4);

        // Gapped bits
        d0 = dv_seen;
        frame(8'hB4, 1'b1, 1'b0, 2'd2, 8);
        finish_frame("gapped");
        check("gapped_dv_count", 32'(dv_seen - d0), 1);

        // Abort after 5 bits, then a full 0x3C frame
        d0 = dv_seen;
        e0 = err_seen;
        frame(8'hF8, 1'b0, 1'b0, 2'd0, 5);
        frame(8'h3C, 1'b0, 1'b0, 2'd3, 8);
        finish_frame("abort");
        check("abort_err_count", 32'(err_seen - e0), 1);
        check("abort_dv_count", 32'(dv_seen - d0), 1);

        // Reset mid-frame: partial frame discarded silently
        e0 = err_seen;
        frame(8'hAA, 1'b0, 1'b0, 2'd0, 4);
        do_reset();
        check("midrst_err_count", 32'(err_seen - e0), 0);

        // Back-to-back: soc in the DONE cycle of the first frame
        d0 = dv_seen;
        e0 = err_seen;
        frame(8'h01, 1'b0, 1'b0, 2'd1, 8);
        frame(8'hFF, 1'b0, 1'b1, 2'd2, 8);
        finish_frame("b2b");
        check("b2b_dv_count", 32'(dv_seen - d0), 2);
        check("b2b_err_count", 32'(err_seen - e0), 0);
        check("b2b_cnt", 32'(sample_cnt), 2);

        // Counter wrap with a 2-bit counter
        do_reset();
        frame(8'h10, 1'b0, 1'b0, 2'd1, 8); finish_frame("wrap0");
        frame(8'h80, 1'b0, 1'b0, 2'd2, 8); finish_frame("wrap1");
        frame(8'h05, 1'b0, 1'b0, 2'd3, 8); finish_frame("wrap2");
        frame(8'h7F, 1'b0, 1'b0, 2'd0, 8); finish_frame("wrap3");
        frame(8'h20, 1'b0, 1'b0, 2'd1, 8); finish_frame("wrap4");
        check("wrap_final_pdata", 32'(pdata_out), 32'h020);

`ifdef SINE_DESER_PEAK_EN
        check("peak_max", 32'(peak_max), 32'h080);
        check("peak_min", 32'(peak_min), 32'h005);
        @(negedge clk);
        peak_clr = 1'b1;
        @(negedge clk);
        peak_clr = 1'b0;
        check("peak_max_clr", 32'(peak_max), 32'h000);
        check("peak_min_clr", 32'(peak_min), 32'h0FF);
`endif

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sine_deserializer.md
Name: sine_deserializer

Overview:
- Receiver stage directly downstream of the sine width/serializer stage.
- Consumes the serial sample stream (SO, SI_en, soc) and rebuilds parallel DATA_WIDTH-bit sine samples, MSB first.
- Presents each sample with a one-cycle valid pulse, a running sample count and a framing-error flag to the checker/DAC-model logic.

Parameters:
- DATA_WIDTH, 8, bits per sample frame (2..16).
- CNT_WIDTH, 16, width of the received-sample counter.

Ports:
- clk  input  1  system clock (100 MHz); all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- SI  input  1  serial data, driven by the upstream SO.
- SI_en  input  1  bit-valid qualifier; SI is sampled only when high.
- soc  input  1  start of conversion; marks the first bit of a frame.
- pdata_out  output  DATA_WIDTH  last completed sample.
- data_valid  output  1  one-cycle pulse when pdata_out updates.
- busy  output  1  high while a frame is being assembled.
- frame_err  output  1  one-cycle pulse on an aborted frame.
- sample_cnt  output  CNT_WIDTH  number of completed frames; wraps.

Behaviour:
- Reset, with rst_n low at a clk edge, overrides everything:
  - pdata_out=0, data_valid=0, busy=0, frame_err=0, sample_cnt=0.
  - Shift register and bit counter cleared; FSM enters IDLE.
- The bit counter is $clog2(DATA_WIDTH+1) bits wide.
- FSM state IDLE:
  - busy=0.
  - soc=1 and SI_en=1: SI is captured as bit 0 of the shift register, bit_cnt=1, go SHIFT.
  - soc=1 and SI_en=0: bit_cnt=0, go SHIFT; the first bit is taken on the next SI_en.
  - SI_en without soc is ignored.
- FSM state SHIFT:
  - busy=1.
  - Each cycle with SI_en=1: shreg <= {shreg[DATA_WIDTH-2:0], SI}, bit_cnt+1.
  - Cycles with SI_en=0 hold the shift register and bit counter.
  - When the DATA_WIDTH-th bit is captured, go DONE on the next edge.
- FSM state DONE (one cycle):
  - pdata_out <= shreg, data_valid=1 for exactly this cycle, sample_cnt+1.
  - busy=0; return to IDLE.
  - soc=1 in DONE is honoured as a new frame start, behaving as IDLE so no frame is dropped. The completing output still happens in the same cycle.
- Frame-completion latency: data_valid asserts 1 cycle after the edge that samples the last bit.
- soc=1 while in SHIFT with bit_cnt>0 (premature restart):
  - frame_err pulses for 1 cycle; the partial data is discarded.
  - pdata_out and sample_cnt are unchanged.
  - The new frame starts with the same rules as IDLE.
- soc=1 in SHIFT with bit_cnt=0: treated as a plain restart with no error.
- sample_cnt wraps from 2^CNT_WIDTH-1 to 0 silently.
- There is no backpressure. Each pdata_out value stays stable until the next data_valid.
- Reset mid-frame discards the partial frame and produces no frame_err.

Optional Feature:
- Macro: SINE_DESER_PEAK_EN.
- When defined:
  - Adds outputs peak_max and peak_min, each DATA_WIDTH wide, holding the unsigned max and min of all completed samples since reset.
  - Adds input peak_clr (1 bit), a synchronous clear of the peak outputs.
  - Both peak outputs update in the same cycle as data_valid.
  - Reset values: peak_max=0 and peak_min=all-ones.
  - peak_clr also restores these reset values; if peak_clr and data_valid occur together, peak_clr wins.
- When not defined: the ports and peak logic are absent, and all other behaviour is identical.

Test Plan:
- Reset check: hold rst_n=0 for 3 cycles while toggling SI, SI_en and soc. All outputs stay 0 and busy=0.
- Single frame: soc+SI_en with bits 1,0,1,1,0,1,0,0 on consecutive cycles.
  - pdata_out=8'hB4, data_valid high exactly 1 cycle after the 8th bit, sample_cnt=1.
- Gapped bits: same frame with SI_en=0 inserted for 2 cycles after bits 3 and 6.
  - pdata_out=8'hB4, busy high throughout the frame, and still exactly one data_valid.
- Abort: soc reasserted after 5 bits, followed by a full frame of 8'h3C.
  - frame_err pulses once, then pdata_out=8'h3C and sample_cnt increments by 1 only.
- Back-to-back: soc asserted in the DONE cycle of frame 8'h01, then frame 8'hFF.
  - Both data_valid pulses occur, sample_cnt=2, and no frame_err.
- Wrap/peak: with CNT_WIDTH=2, send 5 frames: 8'h10, 8'h80, 8'h05, 8'h7F, 8'h20.
  - sample_cnt reads 1,2,3,0,1.
  - With SINE_DESER_PEAK_EN: peak_max=8'h80 and peak_min=8'h05; after peak_clr, peak_max=0 and peak_min=8'hFF.
